// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetchState_t;

    localparam int DEFAULT_WORD_WIDTH = 32;
    localparam int PC_STEP            = 4;
    // Low address bits cleared to force word alignment of a redirect target.
    localparam int PC_ALIGN_MASK      = PC_STEP - 1;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of {pc, code} entries with synchronous flush and occupancy count.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign doPush  = push && !full && !flush;
    assign doPop   = pop && !empty && !flush;
    assign popData = mem[rdPtr];

    // Storage carries no reset; entries are only ever read behind a valid count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch FSM and PC logic feeding the prefetch FIFO; one outstanding memory request.
// Define IFETCH_BYPASS_EN to forward an acked word straight to the core when the FIFO is empty.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int                    DEPTH      = 4,
    parameter int                    WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    mem_req,
    output logic [WORD_WIDTH-1:0]   mem_addr,
    input  logic                    mem_ack,
    input  logic [WORD_WIDTH-1:0]   mem_rdata,
    input  logic                    redirect,
    input  logic [WORD_WIDTH-1:0]   redirect_pc,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [WORD_WIDTH-1:0]   inst_code,
    output logic [WORD_WIDTH-1:0]   inst_pc,
    output fetchState_t             dbgState,
    output logic [$clog2(DEPTH):0]  dbgCount
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Handshakes: a memory word transfers at an edge with mem_req && mem_ack, and mem_req/mem_addr
    // hold until then; an instruction transfers at an edge with inst_valid && inst_ready.
    fetchState_t           state;
    fetchState_t           stateNext;
    logic [WORD_WIDTH-1:0] fetchPc;
    logic [WORD_WIDTH-1:0] fetchPcNext;
    logic [WORD_WIDTH-1:0] addrQ;
    logic [WORD_WIDTH-1:0] addrNext;

    logic [WORD_WIDTH-1:0] targetPc;
    logic [WORD_WIDTH-1:0] pcInc;
    logic [WORD_WIDTH-1:0] headCode;
    logic [WORD_WIDTH-1:0] headPc;
    logic [CNT_W-1:0]      fifoCount;
    logic [CNT_W-1:0]      countAfter;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  fifoPush;
    logic                  fifoPop;
    logic                  hasSpace;
    logic                  bypassHit;
    logic                  bypassTake;

    assign targetPc = redirect_pc & ~WORD_WIDTH'(PC_ALIGN_MASK);
    assign pcInc    = addrQ + WORD_WIDTH'(PC_STEP);

`ifdef IFETCH_BYPASS_EN
    assign bypassHit = fifoEmpty && (state == REQ) && mem_ack && !redirect;
`else
    assign bypassHit = 1'b0;
`endif
    assign bypassTake = bypassHit && inst_ready;

    // A redirect wins over both sides of the FIFO in its cycle.
    assign fifoPush   = (state == REQ) && mem_ack && !redirect && !bypassTake;
    assign fifoPop    = !fifoEmpty && inst_ready && !redirect;
    assign countAfter = fifoCount + CNT_W'(fifoPush) - CNT_W'(fifoPop);
    assign hasSpace   = (countAfter < CNT_W'(DEPTH));

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * WORD_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push     (fifoPush),
        .pushData ({addrQ, mem_rdata}),
        .pop      (fifoPop),
        .popData  ({headPc, headCode}),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
            addrQ   <= RESET_PC;
        end else begin
            state   <= stateNext;
            fetchPc <= fetchPcNext;
            addrQ   <= addrNext;
        end
    end

    // fetchPc holds the redirect target while DROP waits out the abandoned request.
    always_comb begin
        stateNext   = state;
        fetchPcNext = fetchPc;
        addrNext    = addrQ;
        if (redirect) begin
            fetchPcNext = targetPc;
            if ((state != IDLE) && !mem_ack) begin
                stateNext = DROP;
            end else begin
                stateNext = REQ;
                addrNext  = targetPc;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!fifoFull || fifoPop) begin
                        stateNext = REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        fetchPcNext = pcInc;
                        addrNext    = pcInc;
                        stateNext   = hasSpace ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (mem_ack) begin
                        stateNext = REQ;
                        addrNext  = fetchPc;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req    = (state != IDLE);
        mem_addr   = addrQ;
        inst_valid = !fifoEmpty;
        inst_code  = fifoEmpty ? '0 : headCode;
        inst_pc    = fifoEmpty ? '0 : headPc;
        if (bypassHit) begin
            inst_valid = 1'b1;
            inst_code  = mem_rdata;
            inst_pc    = addrQ;
        end
    end

    assign dbgState = state;
    assign dbgCount = fifoCount;

endmodule
